// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed RISC-V load/store front end for a 64-bit doubleword memory
module load_store_unit #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] Address,
    output logic [63:0] Write_data,
    input  logic [63:0] ReadData
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MERGE,
        WR,
        RESP
    } state_t;

    localparam logic [60:0] DEPTH_IDX = 61'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [2:0]  off_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic [63:0] wdata_q;
    logic        accept;
    logic [2:0]  align_mask;
    logic        req_err;

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Any nonzero offset bit below the access size means misaligned.
    always_comb begin
        align_mask = 3'b000;
        case (req_funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_err = (req_funct3 == 3'b111)
               || (req_write && req_funct3[2])
               || ((req_addr[2:0] & align_mask) != 3'b000)
               || (req_addr[63:3] >= DEPTH_IDX);
    end

    function automatic logic [63:0] extend_load(input logic [63:0] dw,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic [63:0] field;
        logic        sgn;
        field = dw >> {off, 3'b000};
        sgn   = ~f3[2];
        case (f3[1:0])
            2'b00:   extend_load = {{56{sgn & field[7]}},  field[7:0]};
            2'b01:   extend_load = {{48{sgn & field[15]}}, field[15:0]};
            2'b10:   extend_load = {{32{sgn & field[31]}}, field[31:0]};
            default: extend_load = field;
        endcase
    endfunction

    function automatic logic [63:0] merge_store(input logic [63:0] dw,
                                                input logic [63:0] wdata,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic [63:0] mask;
        case (f3[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mask        = mask << {off, 3'b000};
        merge_store = (dw & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_write && (req_funct3[1:0] == 2'b11)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = write_q ? MERGE : RESP;
            MERGE:   state_next = WR;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Enables and response flags are registered from the next state so nothing
    // on the memory side depends combinationally on req_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q      <= 3'b000;
            funct3_q   <= 3'b000;
            write_q    <= 1'b0;
            wdata_q    <= 64'h0;
            Address    <= 64'h0;
            Write_data <= 64'h0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 64'h0;
        end else begin
            MemRead    <= (state_next == RD);
            MemWrite   <= (state_next == WR);
            resp_valid <= (state_next == RESP);
            resp_error <= 1'b0;
            resp_rdata <= 64'h0;

            if (state_next == RESP) begin
                resp_error <= (state == IDLE);
                if ((state == RD) && !write_q) begin
                    resp_rdata <= extend_load(ReadData, off_q, funct3_q);
                end
            end

            if (accept) begin
                off_q    <= req_addr[2:0];
                funct3_q <= req_funct3;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
                Address  <= {3'b000, req_addr[63:3]};
                if (req_write && (req_funct3 == 3'b011) && !req_err) begin
                    Write_data <= req_wdata;
                end
            end

            if ((state == RD) && write_q) begin
                Write_data <= merge_store(ReadData, wdata_q, off_q, funct3_q);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed checks of load_store_unit against a byte-level model
module tb_load_store_unit;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Address;
    logic [63:0] Write_data;
    logic [63:0] ReadData;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .Write_data(Write_data), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    logic [63:0] mem     [0:DEPTH-1];
    logic [63:0] ref_mem [0:DEPTH-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_idx = '0;
    logic [63:0]   pre_data = 64'h0;

    assign ReadData = (MemRead && (Address < 64'(DEPTH))) ? mem[Address[AW-1:0]] : 64'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (MemWrite && (Address < 64'(DEPTH))) mem[Address[AW-1:0]] <= Write_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected transaction profile, filled by the model, consumed by the monitor.
    logic        exp_err, exp_resp;
    int          exp_lat, exp_rd_cyc, exp_wr_cyc;
    logic [63:0] exp_idx, exp_wdw, exp_rdata;
    logic        active = 1'b0;
    logic        done = 1'b0;
    int          cyc = 0;
    logic [63:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int size, off;
        logic [7:0]  b [8];
        logic [63:0] v;
        size       = 1 << f3[1:0];
        off        = int'(a % 64'd8);
        exp_idx    = a >> 3;
        exp_err    = (f3 == 3'd7) || (w && f3[2]) || ((a % 64'(size)) != 64'd0) || (exp_idx >= 64'(DEPTH));
        exp_resp   = 1'b1;
        exp_rdata  = 64'h0;
        exp_wdw    = 64'h0;
        exp_rd_cyc = 0;
        exp_wr_cyc = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else begin
            for (int i = 0; i < 8; i++) b[i] = ref_mem[exp_idx][8*i +: 8];
            if (!w) begin
                exp_lat = 2;
                exp_rd_cyc = 1;
                v = 64'h0;
                for (int i = size - 1; i >= 0; i--) v = (v << 8) | 64'(b[off + i]);
                if (!f3[2] && size < 8 && v[8*size-1]) v = v - (64'd1 << (8 * size));
                exp_rdata = v;
            end else begin
                for (int i = 0; i < size; i++) b[off + i] = wd[8*i +: 8];
                for (int i = 0; i < 8; i++) exp_wdw[8*i +: 8] = b[i];
                ref_mem[exp_idx] = exp_wdw;
                if (size == 8) begin
                    exp_lat = 2;
                    exp_wr_cyc = 1;
                end else begin
                    exp_lat = 4;
                    exp_rd_cyc = 1;
                    exp_wr_cyc = 3;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            cyc++;
            chk1("mem_read", MemRead, cyc == exp_rd_cyc);
            chk1("mem_write", MemWrite, cyc == exp_wr_cyc);
            chk1("resp_valid", resp_valid, exp_resp && (cyc == exp_lat));
            if (MemRead || MemWrite) chk("address", Address, exp_idx);
            if (MemWrite) chk("write_data", Write_data, exp_wdw);
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk1("resp_error", resp_error, exp_err);
                last_rdata = resp_rdata;
                last_err   = resp_error;
                last_lat   = cyc;
            end
            if (cyc >= exp_lat) begin
                active = 1'b0;
                done   = 1'b1;
            end
        end else if (rst_n) begin
            chk1("idle_mem_read", MemRead, 1'b0);
            chk1("idle_mem_write", MemWrite, 1'b0);
            chk1("idle_resp_valid", resp_valid, 1'b0);
        end
    end

    task automatic start_req(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        @(negedge clk);
        chk1("req_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        cyc    = 0;
        done   = 1'b0;
        active = 1'b1;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        model(w, f3, a, wd);
        start_req(w, f3, a, wd);
        wait (done);
        if (!exp_err) chk("mem_contents", mem[exp_idx[AW-1:0]], ref_mem[exp_idx[AW-1:0]]);
    endtask

    task automatic preload(input int idx, input logic [63:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = AW'(idx);
        pre_data = d;
        ref_mem[idx] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] orig, a;
        int r, size, off, idx;
        logic [2:0] f3;

        #1;
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_mem_read", MemRead, 1'b0);
        chk1("rst_mem_write", MemWrite, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_address", Address, 64'h0);
        chk("rst_write_data", Write_data, 64'h0);
        for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom});
        preload(DEPTH - 1, {$urandom, $urandom});
        preload(2, 64'h8877665544332211);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 3'b000, 64'h17, 64'h0);
        chk("lb_rdata", last_rdata, 64'hFFFFFFFFFFFFFF88);
        chk("lb_latency", 64'(last_lat), 64'd2);
        issue(1'b0, 3'b100, 64'h17, 64'h0);
        chk("lbu_rdata", last_rdata, 64'h0000000000000088);
        issue(1'b0, 3'b010, 64'h14, 64'h0);
        chk("lw_rdata", last_rdata, 64'hFFFFFFFF88776655);
        issue(1'b0, 3'b110, 64'h14, 64'h0);
        chk("lwu_rdata", last_rdata, 64'h0000000088776655);
        issue(1'b1, 3'b001, 64'h12, 64'h1234ABCD);
        chk("sh_mem", mem[2], 64'h88776655ABCD2211);
        chk("sh_latency", 64'(last_lat), 64'd4);
        issue(1'b1, 3'b011, 64'h08, 64'h0123456789ABCDEF);
        chk("sd_mem", mem[1], 64'h0123456789ABCDEF);
        chk("sd_latency", 64'(last_lat), 64'd2);
        issue(1'b0, 3'b010, 64'h16, 64'h0);
        chk1("err_lw_misaligned", last_err, 1'b1);
        chk("err_lw_latency", 64'(last_lat), 64'd1);
        issue(1'b0, 3'b011, 64'h2000, 64'h0);
        chk1("err_ld_range", last_err, 1'b1);
        issue(1'b1, 3'b100, 64'h10, 64'hFF);
        chk1("err_sb_unsigned", last_err, 1'b1);
        issue(1'b0, 3'b111, 64'h10, 64'h0);
        chk1("err_funct3_111", last_err, 1'b1);
        issue(1'b0, 3'b011, 64'(8 * (DEPTH - 1)), 64'h0);
        chk1("ld_last_word_ok", last_err, 1'b0);

        // Reset during the MERGE cycle of an sb must leave memory untouched.
        orig       = mem[2];
        exp_idx    = 64'd2;
        exp_err    = 1'b0;
        exp_resp   = 1'b0;
        exp_lat    = 6;
        exp_rd_cyc = 1;
        exp_wr_cyc = 0;
        exp_wdw    = 64'h0;
        exp_rdata  = 64'h0;
        start_req(1'b1, 3'b000, 64'h10, 64'h5A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mrst_req_ready", req_ready, 1'b0);
        chk1("mrst_mem_write", MemWrite, 1'b0);
        chk("mrst_write_data", Write_data, 64'h0);
        chk("mrst_address", Address, 64'h0);
        wait (done);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_mem", mem[2], orig);
        issue(1'b0, 3'b011, 64'h10, 64'h0);
        chk("post_rst_ld", last_rdata, 64'h88776655ABCD2211);

        for (int n = 0; n < 300; n++) begin
            f3   = 3'($urandom_range(0, 7));
            size = 1 << f3[1:0];
            r    = $urandom_range(0, 19);
            idx  = (r < 16) ? r : (r < 18) ? DEPTH - 1 : DEPTH + $urandom_range(0, 3);
            off  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~(size - 1);
            a = (64'(idx) << 3) | 64'(off);
            if (r == 19) a = {$urandom, $urandom};
            issue(1'($urandom), f3, a, {$urandom, $urandom});
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
